// File: rtl/oszto_pkg.sv
// Shared constants for the divider scheduler: FSM encoding, client count and default width.
package oszto_pkg;

    localparam int N_CLIENTS    = 2;
    localparam int DEFAULT_BITS = 4;

    localparam logic [2:0] ST_INIT    = 3'd0;
    localparam logic [2:0] ST_IDLE    = 3'd1;
    localparam logic [2:0] ST_START   = 3'd2;
    localparam logic [2:0] ST_BUSY    = 3'd3;
    localparam logic [2:0] ST_RELEASE = 3'd4;
    localparam logic [2:0] ST_ERR     = 3'd5;

endpackage

// File: rtl/oszto.sv
// Multi-cycle divider by repeated subtraction: loads a while idle, two cycles per subtraction,
// ready is held until the next start strobe returns it to idle.
module oszto
    import oszto_pkg::*;
#(
    parameter int BITS = DEFAULT_BITS
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [BITS-1:0] a,
    input  logic [BITS-1:0] b,
    output logic [BITS-1:0] hanyados,
    output logic [BITS-1:0] maradek,
    output logic            ready,
    output logic [1:0]      dbg_state
);

    localparam logic [1:0] D_IDLE = 2'd0;
    localparam logic [1:0] D_CMP  = 2'd1;
    localparam logic [1:0] D_SUB  = 2'd2;
    localparam logic [1:0] D_DONE = 2'd3;

    logic [1:0]      st_q, st_d;
    logic [BITS-1:0] q_q, q_d;
    logic [BITS-1:0] r_q, r_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q <= D_IDLE;
            q_q  <= '0;
            r_q  <= '0;
        end else begin
            st_q <= st_d;
            q_q  <= q_d;
            r_q  <= r_d;
        end
    end

    always_comb begin
        st_d = st_q;
        q_d  = q_q;
        r_d  = r_q;
        case (st_q)
            D_IDLE: begin
                r_d = a;
                q_d = '0;
                if (start) begin
                    st_d = D_CMP;
                end else if (b == '0) begin
                    // A zero divisor has nothing to iterate, so the divider finishes on its own.
                    st_d = D_DONE;
                end
            end
            D_CMP: begin
                st_d = (r_q < b) ? D_DONE : D_SUB;
            end
            D_SUB: begin
                r_d  = r_q - b;
                q_d  = q_q + 1'b1;
                st_d = D_CMP;
            end
            default: begin
                if (start) begin
                    st_d = D_IDLE;
                end
            end
        endcase
    end

    always_comb begin
        hanyados  = q_q;
        maradek   = r_q;
        ready     = (st_q == D_DONE);
        dbg_state = st_q;
    end

endmodule

// File: rtl/rr_valaszto2.sv
// Combinational two-way round-robin picker: on contention the client opposite the last grant wins.
module rr_valaszto2 (
    input  logic [1:0] req_valid,
    input  logic       last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        case (req_valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/oszto_utemezo.sv
// Two-client scheduler for one shared oszto divider: arbitrates, runs the start/release
// handshake and routes quotient, remainder and divide-by-zero back to the requester.
//
// Handshake: a job on client i is taken on a rising edge where req_valid[i] & req_ready[i];
// req_ready is only offered in IDLE, to one client, and only while that client is valid.
// resp_valid is a one-cycle one-hot pulse; resp data holds until the next response.
module oszto_utemezo
    import oszto_pkg::*;
#(
    parameter int BITS = DEFAULT_BITS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req_valid,
    input  logic [2*BITS-1:0] req_a,
    input  logic [2*BITS-1:0] req_b,
    output logic [1:0]        req_ready,
    output logic [1:0]        resp_valid,
    output logic [BITS-1:0]   resp_hanyados,
    output logic [BITS-1:0]   resp_maradek,
    output logic              resp_hiba,
    output logic              div_rst,
    output logic              div_start,
    output logic [BITS-1:0]   div_a,
    output logic [BITS-1:0]   div_b,
    input  logic [BITS-1:0]   div_hanyados,
    input  logic [BITS-1:0]   div_maradek,
    input  logic              div_ready,
    output logic [2:0]        dbg_state
);

    // The divider finishes spontaneously on a zero divisor, so the parked divisor is one.
    localparam logic [BITS-1:0] PARK_B = BITS'(1);

    logic [2:0]      state_q, state_d;
    logic            id_q, id_d;
    logic            last_q, last_d;
    logic [1:0]      resp_valid_q, resp_valid_d;
    logic [BITS-1:0] resp_hanyados_q, resp_hanyados_d;
    logic [BITS-1:0] resp_maradek_q, resp_maradek_d;
    logic            resp_hiba_q, resp_hiba_d;
    logic [BITS-1:0] div_a_q, div_a_d;
    logic [BITS-1:0] div_b_q, div_b_d;

    logic [1:0]      grant;
    logic            accept;
    logic [BITS-1:0] a_sel;
    logic [BITS-1:0] b_sel;

    rr_valaszto2 u_rr (
        .req_valid  (req_valid),
        .last_grant (last_q),
        .grant      (grant)
    );

    assign accept = (state_q == ST_IDLE) && (grant != 2'b00);
    assign a_sel  = grant[1] ? req_a[BITS +: BITS] : req_a[0 +: BITS];
    assign b_sel  = grant[1] ? req_b[BITS +: BITS] : req_b[0 +: BITS];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= ST_INIT;
            id_q            <= 1'b0;
            last_q          <= 1'b1;
            resp_valid_q    <= 2'b00;
            resp_hanyados_q <= '0;
            resp_maradek_q  <= '0;
            resp_hiba_q     <= 1'b0;
            div_a_q         <= '0;
            div_b_q         <= PARK_B;
        end else begin
            state_q         <= state_d;
            id_q            <= id_d;
            last_q          <= last_d;
            resp_valid_q    <= resp_valid_d;
            resp_hanyados_q <= resp_hanyados_d;
            resp_maradek_q  <= resp_maradek_d;
            resp_hiba_q     <= resp_hiba_d;
            div_a_q         <= div_a_d;
            div_b_q         <= div_b_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT:    state_d = ST_IDLE;
            ST_IDLE: begin
                if (accept) begin
                    state_d = (b_sel == '0) ? ST_ERR : ST_START;
                end
            end
            ST_START:   state_d = ST_BUSY;
            ST_BUSY: begin
                if (div_ready) begin
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: state_d = ST_IDLE;
            ST_ERR:     state_d = ST_IDLE;
            default:    state_d = ST_INIT;
        endcase
    end

    always_comb begin
        id_d            = id_q;
        last_d          = last_q;
        resp_valid_d    = 2'b00;
        resp_hanyados_d = resp_hanyados_q;
        resp_maradek_d  = resp_maradek_q;
        resp_hiba_d     = resp_hiba_q;
        div_a_d         = div_a_q;
        div_b_d         = div_b_q;
        case (state_q)
            ST_IDLE: begin
                div_a_d = '0;
                div_b_d = PARK_B;
                if (accept) begin
                    id_d   = grant[1];
                    last_d = grant[1];
                    if (b_sel == '0) begin
                        resp_valid_d    = grant;
                        resp_hiba_d     = 1'b1;
                        resp_hanyados_d = '0;
                        resp_maradek_d  = a_sel;
                    end else begin
                        div_a_d = a_sel;
                        div_b_d = b_sel;
                    end
                end
            end
            ST_START: ;
            ST_BUSY: begin
                if (div_ready) begin
                    resp_valid_d    = id_q ? 2'b10 : 2'b01;
                    resp_hanyados_d = div_hanyados;
                    resp_maradek_d  = div_maradek;
                    resp_hiba_d     = 1'b0;
                    div_a_d         = '0;
                    div_b_d         = PARK_B;
                end
            end
            default: begin
                div_a_d = '0;
                div_b_d = PARK_B;
            end
        endcase
    end

    always_comb begin
        req_ready     = (state_q == ST_IDLE) ? grant : 2'b00;
        div_start     = (state_q == ST_START) || (state_q == ST_RELEASE);
        div_rst       = (state_q == ST_INIT);
        resp_valid    = resp_valid_q;
        resp_hanyados = resp_hanyados_q;
        resp_maradek  = resp_maradek_q;
        resp_hiba     = resp_hiba_q;
        div_a         = div_a_q;
        div_b         = div_b_q;
        dbg_state     = state_q;
    end

endmodule

// File: tb/tb_oszto_utemezo.sv
// Bench for oszto_utemezo driving a real oszto: table of single jobs, then contention and
// mid-job reset sequences, with an expected-response queue and a final report.
module tb_oszto_utemezo;
    import oszto_pkg::*;

    localparam int BITS = 4;
    localparam int W    = 2 + 1 + 2 * BITS;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [1:0]        req_valid = 2'b00;
    logic [2*BITS-1:0] req_a = '0;
    logic [2*BITS-1:0] req_b = '0;
    logic [1:0]        req_ready;
    logic [1:0]        resp_valid;
    logic [BITS-1:0]   resp_hanyados;
    logic [BITS-1:0]   resp_maradek;
    logic              resp_hiba;
    logic              div_rst;
    logic              div_start;
    logic [BITS-1:0]   div_a;
    logic [BITS-1:0]   div_b;
    logic [BITS-1:0]   div_hanyados;
    logic [BITS-1:0]   div_maradek;
    logic              div_ready;
    logic [2:0]        dbg_state;
    logic [1:0]        div_dbg_state;

    oszto_utemezo #(.BITS(BITS)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_a         (req_a),
        .req_b         (req_b),
        .req_ready     (req_ready),
        .resp_valid    (resp_valid),
        .resp_hanyados (resp_hanyados),
        .resp_maradek  (resp_maradek),
        .resp_hiba     (resp_hiba),
        .div_rst       (div_rst),
        .div_start     (div_start),
        .div_a         (div_a),
        .div_b         (div_b),
        .div_hanyados  (div_hanyados),
        .div_maradek   (div_maradek),
        .div_ready     (div_ready),
        .dbg_state     (dbg_state)
    );

    oszto #(.BITS(BITS)) u_div (
        .clk       (clk),
        .rst       (div_rst),
        .start     (div_start),
        .a         (div_a),
        .b         (div_b),
        .hanyados  (div_hanyados),
        .maradek   (div_maradek),
        .ready     (div_ready),
        .dbg_state (div_dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int checks   = 0;
    int failures = 0;
    logic [W-1:0] exp_q[$];
    int expected_total = 0;

    // passive monitors, each owning its own counters
    int start_count = 0;
    int resp_count  = 0;
    int onehot_viol = 0;
    int grant_log[$];

    always @(negedge clk) begin
        if (div_start) start_count++;
        if (resp_valid != 2'b00) resp_count++;
        if ($countones(resp_valid) > 1) onehot_viol++;
        if ((req_valid & req_ready) != 2'b00) grant_log.push_back(req_ready[1] ? 1 : 0);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push_exp(input int id, input logic hiba, input logic [BITS-1:0] q,
                            input logic [BITS-1:0] r);
        logic [1:0] oh;
        oh = (id == 1) ? 2'b10 : 2'b01;
        exp_q.push_back({oh, hiba, q, r});
        expected_total++;
    endtask

    task automatic check_resp(input string name);
        logic [W-1:0] exp;
        logic [W-1:0] act;
        act = {resp_valid, resp_hiba, resp_hanyados, resp_maradek};
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL %s_unexpected: got 0x%0h expected no response", name, act);
        end else begin
            exp = exp_q.pop_front();
            if (act !== exp) begin
                failures++;
                $display("FAIL %s_resp: got 0x%0h expected 0x%0h", name, act, exp);
            end
        end
    endtask

    task automatic check_reset_values(input string name);
        chk({name, "_div_rst"}, 32'(div_rst), 1);
        chk({name, "_div_b"}, 32'(div_b), 1);
        chk({name, "_div_a"}, 32'(div_a), 0);
        chk({name, "_div_start"}, 32'(div_start), 0);
        chk({name, "_req_ready"}, 32'(req_ready), 0);
        chk({name, "_resp_valid"}, 32'(resp_valid), 0);
        chk({name, "_resp_data"}, 32'({resp_hiba, resp_hanyados, resp_maradek}), 0);
        chk({name, "_state"}, 32'(dbg_state), 32'(ST_INIT));
    endtask

    task automatic apply_reset(input string name);
        @(posedge clk);
        #2 rst = 1'b0;
        req_valid = 2'b00;
        repeat (3) @(negedge clk);
        check_reset_values(name);
        @(posedge clk);
        #2 rst = 1'b1;
    endtask

    // driver: offer one job, wait for acceptance, measure edges to resp_valid
    task automatic run_job(input int id, input logic [BITS-1:0] a, input logic [BITS-1:0] b,
                           input logic [BITS-1:0] eq, input logic [BITS-1:0] er,
                           input logic eh, input int elat, input int estarts, input string name);
        int  n;
        int  s0;
        bit  got;
        @(posedge clk);
        #2;
        req_valid[id]           = 1'b1;
        req_a[id*BITS +: BITS]  = a;
        req_b[id*BITS +: BITS]  = b;
        push_exp(id, eh, eq, er);
        s0  = start_count;
        got = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (req_ready[id]) begin
                got = 1'b1;
                break;
            end
        end
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL %s_accept: got no req_ready expected accept within 200 cycles", name);
            req_valid[id] = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        req_valid[id]          = 1'b0;
        req_a[id*BITS +: BITS] = BITS'($urandom_range(0, 15));
        req_b[id*BITS +: BITS] = BITS'($urandom_range(0, 15));
        n = 0;
        while (resp_valid == 2'b00 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({name, "_latency"}, n, elat);
        if (resp_valid != 2'b00) check_resp(name);
        if (eh) begin
            chk({name, "_err_div_b"}, 32'(div_b), 1);
            chk({name, "_err_div_start"}, 32'(div_start), 0);
        end
        repeat (3) @(negedge clk);
        chk({name, "_starts"}, start_count - s0, estarts);
    endtask

    typedef struct {
        int              id;
        logic [BITS-1:0] a;
        logic [BITS-1:0] b;
        logic [BITS-1:0] q;
        logic [BITS-1:0] r;
        logic            hiba;
        int              lat;
        int              starts;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int gl0;
        int n_resp;
        int exp_grants[4];
        bit got;

        // latency = edges from the accept edge to the edge that raises resp_valid (3+2q, or 0 on /0)
        vecs[0] = '{0, 4'd7,  4'd2,  4'd3, 4'd1, 1'b0, 9, 2};
        vecs[1] = '{1, 4'd1,  4'd3,  4'd0, 4'd1, 1'b0, 3, 2};
        vecs[2] = '{0, 4'd9,  4'd0,  4'd0, 4'd9, 1'b1, 0, 0};
        vecs[3] = '{1, 4'd13, 4'd5,  4'd2, 4'd3, 1'b0, 7, 2};
        vecs[4] = '{0, 4'd0,  4'd7,  4'd0, 4'd0, 1'b0, 3, 2};
        vecs[5] = '{1, 4'd15, 4'd15, 4'd1, 4'd0, 1'b0, 5, 2};
        vecs[6] = '{0, 4'd0,  4'd0,  4'd0, 4'd0, 1'b1, 0, 0};
        exp_grants = '{0, 1, 0, 1};

        repeat (3) @(negedge clk);
        check_reset_values("reset");
        @(posedge clk);
        #2 rst = 1'b1;

        for (int i = 0; i < 7; i++) begin
            run_job(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].hiba,
                    vecs[i].lat, vecs[i].starts, $sformatf("vec%0d", i));
        end

        // contention after a fresh reset: client 0 first, then strict alternation
        apply_reset("reset2");
        @(posedge clk);
        #2;
        req_a = {4'd8, 4'd15};
        req_b = {4'd4, 4'd1};
        req_valid = 2'b11;
        push_exp(0, 1'b0, 4'd15, 4'd0);
        push_exp(1, 1'b0, 4'd2,  4'd0);
        push_exp(0, 1'b0, 4'd15, 4'd0);
        push_exp(1, 1'b0, 4'd2,  4'd0);
        gl0    = grant_log.size();
        n_resp = 0;
        for (int k = 0; k < 2000 && n_resp < 4; k++) begin
            @(posedge clk);
            #1;
            if (grant_log.size() - gl0 >= 4) req_valid = 2'b00;
            if (resp_valid != 2'b00) begin
                check_resp($sformatf("rr%0d", n_resp));
                n_resp++;
            end
        end
        req_valid = 2'b00;
        chk("rr_resp_count", n_resp, 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rr_grant%0d", i),
                (grant_log.size() > gl0 + i) ? grant_log[gl0 + i] : -1, exp_grants[i]);
        end

        // reset in the middle of BUSY abandons the job without a response
        repeat (3) @(posedge clk);
        #2;
        req_valid[0] = 1'b1;
        req_a[3:0]   = 4'd15;
        req_b[3:0]   = 4'd1;
        got = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (req_ready[0]) begin
                got = 1'b1;
                break;
            end
        end
        chk("midrst_accept", 32'(got), 1);
        @(posedge clk);
        #1 req_valid = 2'b00;
        repeat (10) @(posedge clk);
        #1;
        chk("midrst_busy_state", 32'(dbg_state), 32'(ST_BUSY));
        n_resp = resp_count;
        apply_reset("midrst");
        repeat (40) @(negedge clk);
        chk("midrst_no_resp", resp_count - n_resp, 0);
        run_job(0, 4'd6, 4'd3, 4'd2, 4'd0, 1'b0, 7, 2, "after_rst");

        // final report
        chk("resp_onehot", onehot_viol, 0);
        chk("resp_pulses", resp_count, expected_total);
        chk("exp_q_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
